// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants and the 64-bit word type.
package legv8_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 64;

   typedef logic [63:0] word_t;

endpackage

// File: rtl/ram_addr_check.sv
// Full-width word-address range check (address < DEPTH); purely combinational.
// Zero latency, no handshake: gates both the write enable and the read mux.
module ram_addr_check
   import legv8_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 64
) (
   input  logic [ADDR_W-1:0] address,
   output logic              in_range
);

   // Compared at the full bus width so high address bits never alias into the array.
   localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

   always_comb begin
      in_range = (address < DEPTH_W);
   end

endmodule

// File: rtl/ram.sv
// LEGv8 data memory: DEPTH x 64-bit words, combinational read, write on rising edge.
// Read latency 0, write latency 1 edge; no handshake, enables are level-sensitive each edge.
module ram
   import legv8_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] out
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   word_t            mem_q [0:DEPTH-1];
   logic             in_range;
   logic             wr_en;
   logic             rd_en;
   logic [IDX_W-1:0] idx;

   ram_addr_check #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_addr_check (
      .address  (address),
      .in_range (in_range)
   );

   // Only the low index bits select the word; in_range already rejects anything above.
   always_comb begin
      idx   = address[IDX_W-1:0];
      wr_en = reset_n && write && in_range;
      rd_en = reset_n && read && in_range;
   end

   always_comb begin
      out = '0;
      if (rd_en) begin
         out = mem_q[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[idx] <= data;
      end
   end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: array model checked every negedge plus directed literal checks.
module tb_ram;

   localparam int DEPTH = 64;

   logic        clk;
   logic        reset_n;
   logic [63:0] address;
   logic        read;
   logic        write;
   logic [63:0] data;
   logic [63:0] out;

   int total = 0;
   int bad   = 0;

   logic [63:0] mdl [DEPTH];

   ram #(
      .DEPTH  (DEPTH),
      .DATA_W (64),
      .ADDR_W (64)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .address (address),
      .read    (read),
      .write   (write),
      .data    (data),
      .out     (out)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Reference memory: what the words must hold after each edge.
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mdl[i] <= 64'd0;
      end else if (write && address < 64'(DEPTH)) begin
         mdl[address[5:0]] <= data;
      end
   end

   function automatic logic [63:0] expect_out();
      if (reset_n && read && address < 64'(DEPTH)) return mdl[address[5:0]];
      return 64'd0;
   endfunction

   always @(negedge clk) begin
      logic [63:0] e;
      e = expect_out();
      total++;
      if (out !== e) begin
         bad++;
         $display("FAIL model t=%0t addr=%h out=%h expected=%h", $time, address, out, e);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] exp);
      #1;
      total++;
      if (out !== exp) begin
         bad++;
         $display("FAIL %s: out=%h expected=%h", nm, out, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      read    = 1'b1;
      write   = 1'b0;
      address = 64'd0;
      data    = 64'd0;
      chk("out_in_reset", 64'd0);
      step();
      reset_n = 1'b1;
      read = 1'b1; address = 64'd0; chk("reset_rd0", 64'd0);
      address = 64'd3;              chk("reset_rd3", 64'd0);
      step();

      read = 1'b0; write = 1'b1; address = 64'd0; data = 64'd5;
      step();
      address = 64'd1; data = 64'd684;
      step();
      write = 1'b0; read = 1'b1;
      address = 64'd0; chk("wr_rd0", 64'd5);
      address = 64'd1; chk("wr_rd1", 64'd684);
      read = 1'b0;     chk("rd_disabled", 64'd0);
      read = 1'b1;     chk("rd_reenabled", 64'd684);
      step();

      write = 1'b1; address = 64'd2; data = 64'd7;
      step();
      data = 64'd9; chk("rw_before_edge", 64'd7);
      step();
      write = 1'b0; chk("rw_after_edge", 64'd9);
      step();

      write = 1'b1; address = 64'd64; data = 64'hDEAD;
      step();
      write = 1'b0; chk("oor_rd64", 64'd0);
      address = 64'd0; chk("oor_rd0_kept", 64'd5);
      step();

      write = 1'b1; address = 64'h1_0000_0001; data = 64'hBEEF;
      step();
      write = 1'b0; chk("alias_hi_rd", 64'd0);
      address = 64'd1; chk("alias_rd1_kept", 64'd684);
      step();

      write = 1'b1; address = 64'd63; data = 64'h1234_5678_9ABC_DEF0;
      step();
      write = 1'b0; chk("edge_rd63", 64'h1234_5678_9ABC_DEF0);
      step();

      write = 1'b1; address = 64'd4;
      for (int k = 1; k <= 3; k++) begin
         data = 64'(k);
         step();
      end
      write = 1'b0; data = 64'd99;
      step();
      chk("hold_last_wins", 64'd3);

      reset_n = 1'b0; write = 1'b1; address = 64'd0; data = 64'd11;
      chk("mid_reset_out", 64'd0);
      step();
      reset_n = 1'b1; write = 1'b0;
      chk("mid_reset_rd0", 64'd0);
      address = 64'd1;  chk("mid_reset_rd1", 64'd0);
      address = 64'd63; chk("mid_reset_rd63", 64'd0);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
